uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver FSM encoding, parity helper.
// UART_RX_PARITY_EN adds the PARITY state to the receiver state enum.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;
`endif

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchronizer chain with a falling-edge detect on the synchronized bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES-1:0] vld_p;
  logic                   prev_q;

  // The preset ones are not real line samples; prev_q only takes values that
  // came from the line, so a line held low through reset release is no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p <= '1;
      vld_p  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      vld_p  <= {vld_p[SYNC_STAGES-2:0], 1'b1};
      prev_q <= sync_p[SYNC_STAGES-1] & vld_p[SYNC_STAGES-1];
    end
  end

  assign dout = sync_p[SYNC_STAGES-1];
  assign fall = prev_q & ~dout;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, ready/valid byte output.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop (adds parity_err).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_fall;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_p0;
  logic                 mid_tick;
  logic                 bit_tick;
  logic                 data_sample;
  logic                 accept;
  logic                 frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
  logic                 par_bad;
`endif

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (UART_RX),
    .dout (rx_s),
    .fall (rx_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (rx_fall) state_nxt = ST_START;
      end
      ST_START: begin
        if (mid_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
`ifdef UART_RX_PARITY_EN
        if (bit_tick && bit_cnt == LAST_BIT) state_nxt = ST_PARITY;
`else
        if (bit_tick && bit_cnt == LAST_BIT) state_nxt = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mid_tick    = (cnt == CNT_HALF);
    bit_tick    = (cnt == CNT_FULL);
    data_sample = (state == ST_DATA) && bit_tick;
    frame_bad   = (state == ST_STOP) && bit_tick && !rx_s;
`ifdef UART_RX_PARITY_EN
    par_bad     = (state == ST_STOP) && bit_tick && rx_s && (par_bit != even_parity(shift_p0));
    accept      = (state == ST_STOP) && bit_tick && rx_s && !par_bad;
`else
    accept      = (state == ST_STOP) && bit_tick && rx_s;
`endif
    rx_busy     = (state != ST_IDLE);
  end

  // Bit-period timing: counter restarts on every state change and every bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == ST_IDLE || state_nxt != state || bit_tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state == ST_IDLE && rx_fall) begin
        bit_cnt <= '0;
      end else if (data_sample) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_sample) shift_p0 <= {rx_s, shift_p0[DATA_BITS-1:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (state == ST_PARITY && bit_tick) par_bit <= rx_s;
  end
`endif

  // Output stage: byte and status pulses load on the stop-bit sample edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= frame_bad;
      overrun    <= accept && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= par_bad;
`endif
      if (accept) begin
        rx_data  <= shift_p0;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
